// File: rtl/uart_transceiver.sv
// 8N1 UART transmitter and receiver sharing one clock and CLKS_PER_BIT timing.
// Optional UART_LOOPBACK_EN adds a loopback input that feeds tx_line into the receiver.
module uart_transceiver #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tx_start,
    input  logic [7:0] data_in,
    output logic       tx_line,
    output logic       tx_busy,
    input  logic       rx_serial,
`ifdef UART_LOOPBACK_EN
    input  logic       loopback,
`endif
    output logic [7:0] rx_data,
    output logic       rx_done,
    output logic       framing_error
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] MID_CNT  = CW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT_HIGH} rx_state_t;

    tx_state_t       tx_state;
    logic [CW-1:0]   tx_cnt;
    logic [2:0]      tx_bit;
    logic [7:0]      tx_shift;

    rx_state_t       rx_state;
    logic [CW-1:0]   rx_cnt;
    logic [2:0]      rx_bit;
    logic [7:0]      rx_shift;
    logic [1:0]      rx_sync;
    logic            rx_src;
    logic            rx_in;

`ifdef UART_LOOPBACK_EN
    assign rx_src = loopback ? tx_line : rx_serial;
`else
    assign rx_src = rx_serial;
`endif
    assign rx_in = rx_sync[1];

    // Transmitter: tx_shift is consumed LSB first, one bit per CLKS_PER_BIT cycles
    always_ff @(posedge clk) begin
        if (reset) begin
            tx_state <= TX_IDLE;
            tx_line  <= 1'b1;
            tx_busy  <= 1'b0;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_shift <= '0;
        end else begin
            case (tx_state)
                TX_IDLE: begin
                    tx_line <= 1'b1;
                    tx_busy <= 1'b0;
                    tx_cnt  <= '0;
                    tx_bit  <= '0;
                    if (tx_start) begin
                        tx_shift <= data_in;
                        tx_line  <= 1'b0;
                        tx_busy  <= 1'b1;
                        tx_state <= TX_START;
                    end
                end
                TX_START: begin
                    if (tx_cnt == LAST_CNT) begin
                        tx_cnt   <= '0;
                        tx_line  <= tx_shift[0];
                        tx_shift <= tx_shift >> 1;
                        tx_state <= TX_DATA;
                    end else begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end
                end
                TX_DATA: begin
                    if (tx_cnt == LAST_CNT) begin
                        tx_cnt <= '0;
                        if (tx_bit == 3'd7) begin
                            tx_line  <= 1'b1;
                            tx_state <= TX_STOP;
                        end else begin
                            tx_bit   <= tx_bit + 1'b1;
                            tx_line  <= tx_shift[0];
                            tx_shift <= tx_shift >> 1;
                        end
                    end else begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end
                end
                TX_STOP: begin
                    if (tx_cnt == LAST_CNT) begin
                        tx_cnt   <= '0;
                        tx_busy  <= 1'b0;
                        tx_state <= TX_IDLE;
                    end else begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end
                end
                default: begin
                    tx_state <= TX_IDLE;
                    tx_line  <= 1'b1;
                    tx_busy  <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_sync <= 2'b11;
        end else begin
            rx_sync <= {rx_sync[0], rx_src};
        end
    end

    // Receiver: after the start-bit midpoint every later sample lands mid-bit
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_state      <= RX_IDLE;
            rx_cnt        <= '0;
            rx_bit        <= '0;
            rx_shift      <= '0;
            rx_data       <= '0;
            rx_done       <= 1'b0;
            framing_error <= 1'b0;
        end else begin
            rx_done       <= 1'b0;
            framing_error <= 1'b0;
            case (rx_state)
                RX_IDLE: begin
                    rx_cnt <= '0;
                    rx_bit <= '0;
                    if (!rx_in) begin
                        rx_state <= RX_START;
                    end
                end
                RX_START: begin
                    if (rx_cnt == MID_CNT) begin
                        rx_cnt   <= '0;
                        rx_state <= rx_in ? RX_IDLE : RX_DATA;
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (rx_cnt == LAST_CNT) begin
                        rx_cnt   <= '0;
                        rx_shift <= {rx_in, rx_shift[7:1]};
                        if (rx_bit == 3'd7) begin
                            rx_state <= RX_STOP;
                        end else begin
                            rx_bit <= rx_bit + 1'b1;
                        end
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (rx_cnt == LAST_CNT) begin
                        rx_cnt <= '0;
                        if (rx_in) begin
                            rx_data  <= rx_shift;
                            rx_done  <= 1'b1;
                            rx_state <= RX_IDLE;
                        end else begin
                            framing_error <= 1'b1;
                            rx_state      <= RX_WAIT_HIGH;
                        end
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                RX_WAIT_HIGH: begin
                    if (rx_in) begin
                        rx_state <= RX_IDLE;
                    end
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_transceiver.sv
// Directed self-checking bench for uart_transceiver (default build, CLKS_PER_BIT=16).
// tx_line is looped to rx_serial through use_loop, otherwise rx_drive feeds the receiver.
module tb_uart_transceiver;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       tx_start = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic       tx_line;
    logic       tx_busy;
    logic       rx_serial;
    logic [7:0] rx_data;
    logic       rx_done;
    logic       framing_error;

    logic       use_loop = 1'b1;
    logic       rx_drive = 1'b1;

    int checks = 0;
    int failures = 0;
    int rx_cnt = 0;
    int ferr_cnt = 0;
    logic [7:0] rx_q[$];

    assign rx_serial = use_loop ? tx_line : rx_drive;

    always #5 clk = ~clk;

    uart_transceiver #(.CLKS_PER_BIT(16)) dut (
        .clk           (clk),
        .reset         (reset),
        .tx_start      (tx_start),
        .data_in       (data_in),
        .tx_line       (tx_line),
        .tx_busy       (tx_busy),
        .rx_serial     (rx_serial),
        .rx_data       (rx_data),
        .rx_done       (rx_done),
        .framing_error (framing_error)
    );

    always @(negedge clk) begin
        if (rx_done) begin
            rx_cnt++;
            rx_q.push_back(rx_data);
        end
        if (framing_error) ferr_cnt++;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Drives one 8N1 frame on rx_drive, starting at a negedge
    task automatic applyStimulus(input logic [7:0] value, input logic stop_bit);
        logic [9:0] frame;
        frame = {stop_bit, value, 1'b0};
        for (int b = 0; b < 10; b++) begin
            rx_drive = frame[b];
            repeat (16) @(negedge clk);
        end
        rx_drive = 1'b1;
    endtask

    // Pulses tx_start for the accepting edge; returns 1 time unit after it
    task automatic start_tx(input logic [7:0] value);
        tx_start = 1'b1;
        data_in  = value;
        @(posedge clk);
        #1 tx_start = 1'b0;
    endtask

    function automatic logic [31:0] q_at(input int idx);
        if (rx_q.size() > idx) return {24'h0, rx_q[idx]};
        return 32'hDEAD;
    endfunction

    initial begin
        int busy_cnt;
        int idle_cnt;
        int rx_base;
        int ferr_base;
        logic [9:0] frame_4d;
        frame_4d = 10'b1_0100_1101_0;

        repeat (3) @(negedge clk);
        checkOutput("reset_tx_line", tx_line, 1);
        checkOutput("reset_tx_busy", tx_busy, 0);
        checkOutput("reset_rx_data", rx_data, 0);
        checkOutput("reset_rx_done", rx_done, 0);
        checkOutput("reset_ferr", framing_error, 0);
        reset = 1'b0;
        repeat (4) @(negedge clk);

        // Loopback 0x4D
        rx_base = rx_cnt; ferr_base = ferr_cnt; busy_cnt = 0;
        start_tx(8'h4D);
        for (int n = 0; n < 175; n++) begin
            @(negedge clk);
            if (tx_busy) busy_cnt++;
            if (n < 160 && n % 16 == 8)
                checkOutput($sformatf("tx_bit%0d", n / 16), tx_line, frame_4d[n / 16]);
        end
        checkOutput("4d_busy_cycles", busy_cnt, 160);
        checkOutput("4d_rx_count", rx_cnt - rx_base, 1);
        checkOutput("4d_rx_data", q_at(rx_base), 8'h4D);
        checkOutput("4d_ferr", ferr_cnt - ferr_base, 0);

        // Back-to-back 0x00 then 0xFF with tx_start held
        rx_base = rx_cnt; idle_cnt = 0;
        tx_start = 1'b1; data_in = 8'h00;
        @(posedge clk);
        #1 data_in = 8'hFF;
        for (int n = 0; n < 335; n++) begin
            @(negedge clk);
            if (n <= 320 && !tx_busy) idle_cnt++;
            if (n == 159) checkOutput("b2b_stop_line", tx_line, 1);
            if (n == 160) checkOutput("b2b_idle_line", tx_line, 1);
            if (n == 161) begin
                checkOutput("b2b_start_line", tx_line, 0);
                tx_start = 1'b0;
            end
        end
        checkOutput("b2b_idle_cycles", idle_cnt, 1);
        checkOutput("b2b_rx_count", rx_cnt - rx_base, 2);
        checkOutput("b2b_first", q_at(rx_base), 8'h00);
        checkOutput("b2b_second", q_at(rx_base + 1), 8'hFF);
        repeat (20) @(negedge clk);

        // tx_start during a frame is ignored
        rx_base = rx_cnt; busy_cnt = 0;
        start_tx(8'h3C);
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (n == 80) begin tx_start = 1'b1; data_in = 8'hA5; end
            if (n == 81) tx_start = 1'b0;
            if (n < 160 && tx_busy) busy_cnt++;
            if (n == 165) checkOutput("ign_busy_after", tx_busy, 0);
        end
        checkOutput("ign_busy_cycles", busy_cnt, 160);
        checkOutput("ign_rx_count", rx_cnt - rx_base, 1);
        checkOutput("ign_rx_data", q_at(rx_base), 8'h3C);

        // Framing error, then line held low, then a good frame
        use_loop = 1'b0; rx_drive = 1'b1;
        repeat (10) @(negedge clk);
        rx_base = rx_cnt; ferr_base = ferr_cnt;
        applyStimulus(8'h55, 1'b0);
        rx_drive = 1'b0;
        repeat (50) @(negedge clk);
        checkOutput("fe_pulses", ferr_cnt - ferr_base, 1);
        checkOutput("fe_no_done", rx_cnt - rx_base, 0);
        checkOutput("fe_rx_data_held", rx_data, 8'h3C);
        rx_drive = 1'b1;
        repeat (20) @(negedge clk);
        applyStimulus(8'h12, 1'b1);
        repeat (20) @(negedge clk);
        checkOutput("fe_next_count", rx_cnt - rx_base, 1);
        checkOutput("fe_next_data", q_at(rx_base), 8'h12);
        checkOutput("fe_total_pulses", ferr_cnt - ferr_base, 1);

        // Short low glitch on idle line
        rx_base = rx_cnt; ferr_base = ferr_cnt;
        rx_drive = 1'b0;
        repeat (4) @(negedge clk);
        rx_drive = 1'b1;
        repeat (40) @(negedge clk);
        checkOutput("glitch_no_done", rx_cnt - rx_base, 0);
        checkOutput("glitch_no_ferr", ferr_cnt - ferr_base, 0);
        applyStimulus(8'hC3, 1'b1);
        repeat (20) @(negedge clk);
        checkOutput("glitch_next_count", rx_cnt - rx_base, 1);
        checkOutput("glitch_next_data", q_at(rx_base), 8'hC3);

        // Reset during data bit 4 of a loopback frame
        use_loop = 1'b1;
        repeat (10) @(negedge clk);
        rx_base = rx_cnt; ferr_base = ferr_cnt;
        start_tx(8'hE5);
        for (int n = 0; n < 84; n++) @(negedge clk);
        checkOutput("rst_bit4_low", tx_line, 0);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("rst_tx_line", tx_line, 1);
        checkOutput("rst_tx_busy", tx_busy, 0);
        checkOutput("rst_rx_data", rx_data, 0);
        reset = 1'b0;
        repeat (200) @(negedge clk);
        checkOutput("rst_no_done", rx_cnt - rx_base, 0);
        checkOutput("rst_no_ferr", ferr_cnt - ferr_base, 0);
        start_tx(8'h81);
        repeat (175) @(negedge clk);
        checkOutput("rst_next_count", rx_cnt - rx_base, 1);
        checkOutput("rst_next_data", q_at(rx_base), 8'h81);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
